// File: rtl/surf_cmd_tx_pkg.sv
// Shared definitions for the SURF CMD serial line.
// The SURF-side decoder uses the same levels and parity sense.
package surf_cmd_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_GAP    = 3'd4
    } state_e;

    localparam logic LVL_IDLE  = 1'b0;
    localparam logic LVL_START = 1'b1;
    localparam logic PAR_ODD   = 1'b1;

    // Zero-extended payload: parity over data plus this bit matches PAR_ODD.
    function automatic logic par_bit(input logic [31:0] d);
        return (^d) ^ PAR_ODD;
    endfunction

endpackage

// File: rtl/surf_cmd_tx_if.sv
// Command word valid/ready handshake into the CMD transmitter.
interface surf_cmd_tx_if #(
    parameter int CMD_BITS = 8
) ();

    logic [CMD_BITS-1:0] cmd_data_i;
    logic                cmd_valid_i;
    logic                cmd_ready_o;

    modport master (
        output cmd_data_i,
        output cmd_valid_i,
        input  cmd_ready_o
    );

    modport slave (
        input  cmd_data_i,
        input  cmd_valid_i,
        output cmd_ready_o
    );

endinterface

// File: rtl/surf_cmd_bitclk.sv
// Bit-period strobe generator; restart realigns the period to a frame start.
module surf_cmd_bitclk #(
    parameter int BIT_CYCLES = 1
) (
    input  logic clk33_i,
    input  logic rst_i,
    input  logic restart,
    output logic bit_stb
);

    generate
        if (BIT_CYCLES == 1) begin : g_tie
            logic unused_in;
            assign unused_in = ^{clk33_i, rst_i, restart};
            assign bit_stb   = 1'b1;
        end else begin : g_cnt
            localparam int W = $clog2(BIT_CYCLES);
            logic [W-1:0] cnt_q;

            always_ff @(posedge clk33_i) begin
                if (rst_i || restart || cnt_q == '0) begin
                    cnt_q <= W'(BIT_CYCLES - 1);
                end else begin
                    cnt_q <= cnt_q - 1'b1;
                end
            end

            assign bit_stb = (cnt_q == '0);
        end
    endgenerate

endmodule

// File: rtl/surf_cmd_tx.sv
// Serial CMD transmitter: START, MSB-first payload, odd parity, idle gap.
module surf_cmd_tx
    import surf_cmd_tx_pkg::*;
#(
    parameter int CMD_BITS   = 8,
    parameter int BIT_CYCLES = 1,
    parameter int GAP_BITS   = 2,
    parameter int CNT_BITS   = 16
) (
    input  logic                clk33_i,
    input  logic                rst_i,
    surf_cmd_tx_if.slave        cmd,
    output logic                CMD,
    output logic                busy_o,
    output logic [CNT_BITS-1:0] frame_count_o
);

    localparam int MAXB = (CMD_BITS > GAP_BITS) ? CMD_BITS : GAP_BITS;
    localparam int CW   = $clog2(MAXB) + 1;

    state_e              state_q;
    logic [CMD_BITS-1:0] hold_q;
    logic [CMD_BITS-1:0] shift_q;
    logic                hold_full_q;
    logic                hold_full_d;
    logic                ready_q;
    logic                par_q;
    logic                cmd_q;
    logic                busy_q;
    logic [CW-1:0]       bit_cnt_q;
    logic [CNT_BITS-1:0] cnt_q;
    logic                bit_stb;
    logic                accept;
    logic                last_gap;
    logic                load;
    logic                line;

    assign accept      = cmd.cmd_valid_i & ready_q;
    assign last_gap    = (state_q == ST_GAP) & bit_stb & (bit_cnt_q == '0);
    // The final gap cycle chains straight into the next START.
    assign load        = hold_full_q & ((state_q == ST_IDLE) | last_gap);
    assign hold_full_d = accept | (hold_full_q & ~load);

    surf_cmd_bitclk #(
        .BIT_CYCLES(BIT_CYCLES)
    ) u_bitclk (
        .clk33_i(clk33_i),
        .rst_i  (rst_i),
        .restart(load),
        .bit_stb(bit_stb)
    );

    always_ff @(posedge clk33_i) begin
        if (rst_i) begin
            hold_full_q <= 1'b0;
            ready_q     <= 1'b0;
        end else begin
            hold_full_q <= hold_full_d;
            ready_q     <= ~hold_full_d;
            if (accept) begin
                hold_q <= cmd.cmd_data_i;
            end
        end
    end

    always_comb begin
        line = LVL_IDLE;
        unique case (state_q)
            ST_START:  line = LVL_START;
            ST_DATA:   line = shift_q[CMD_BITS-1];
            ST_PARITY: line = par_q;
            default:   line = LVL_IDLE;
        endcase
    end

    always_ff @(posedge clk33_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            par_q     <= 1'b0;
            cmd_q     <= LVL_IDLE;
            busy_q    <= 1'b0;
            cnt_q     <= '0;
        end else begin
            cmd_q  <= line;
            busy_q <= (state_q != ST_IDLE) | hold_full_q;
            if (last_gap) begin
                cnt_q <= cnt_q + 1'b1;
            end
            unique case (state_q)
                ST_IDLE: begin
                end
                ST_START: begin
                    if (bit_stb) begin
                        state_q   <= ST_DATA;
                        bit_cnt_q <= CW'(CMD_BITS - 1);
                    end
                end
                ST_DATA: begin
                    if (bit_stb) begin
                        if (bit_cnt_q == '0) begin
                            state_q <= ST_PARITY;
                        end else begin
                            shift_q   <= shift_q << 1;
                            bit_cnt_q <= bit_cnt_q - 1'b1;
                        end
                    end
                end
                ST_PARITY: begin
                    if (bit_stb) begin
                        state_q   <= ST_GAP;
                        bit_cnt_q <= CW'(GAP_BITS - 1);
                    end
                end
                ST_GAP: begin
                    if (bit_stb) begin
                        if (bit_cnt_q == '0) begin
                            state_q <= ST_IDLE;
                        end else begin
                            bit_cnt_q <= bit_cnt_q - 1'b1;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
            if (load) begin
                state_q <= ST_START;
                shift_q <= hold_q;
                par_q   <= par_bit(32'(hold_q));
            end
        end
    end

    assign cmd.cmd_ready_o = ready_q;
    assign CMD             = cmd_q;
    assign busy_o          = busy_q;
    assign frame_count_o   = cnt_q;

endmodule

// File: tb/tb_surf_cmd_tx.sv
// Scoreboard bench for surf_cmd_tx: fast-rate and slow-rate instances.
module tb_surf_cmd_tx;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    surf_cmd_tx_if #(.CMD_BITS(8)) if0 ();
    surf_cmd_tx_if #(.CMD_BITS(8)) if1 ();

    logic        cmd0, busy0, cmd1, busy1;
    logic [15:0] cnt0;
    logic [3:0]  cnt1;

    surf_cmd_tx #(
        .CMD_BITS(8), .BIT_CYCLES(1), .GAP_BITS(2), .CNT_BITS(16)
    ) dut0 (
        .clk33_i(clk), .rst_i(rst), .cmd(if0),
        .CMD(cmd0), .busy_o(busy0), .frame_count_o(cnt0)
    );

    surf_cmd_tx #(
        .CMD_BITS(8), .BIT_CYCLES(4), .GAP_BITS(2), .CNT_BITS(4)
    ) dut1 (
        .clk33_i(clk), .rst_i(rst), .cmd(if1),
        .CMD(cmd1), .busy_o(busy1), .frame_count_o(cnt1)
    );

    localparam int FL0 = 12;
    localparam int FL1 = 48;

    int n_tests = 0;
    int n_fail  = 0;
    bit exp0[$];
    bit exp1[$];
    int starts0[$];
    int starts1[$];
    int left0 = 0;
    int left1 = 0;
    int n;
    int highs;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0d want %0d", tag, got, want);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            exp0.delete();
            left0 = 0;
        end else if (left0 > 0) begin
            check("bit0", cmd0, exp0.pop_front());
            left0--;
        end else if (cmd0) begin
            if (exp0.size() == 0) begin
                check("spurious0", cmd0, 0);
            end else begin
                starts0.push_back(cyc);
                check("bit0", cmd0, exp0.pop_front());
                left0 = FL0 - 1;
            end
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            exp1.delete();
            left1 = 0;
        end else if (left1 > 0) begin
            check("bit1", cmd1, exp1.pop_front());
            left1--;
        end else if (cmd1) begin
            if (exp1.size() == 0) begin
                check("spurious1", cmd1, 0);
            end else begin
                starts1.push_back(cyc);
                check("bit1", cmd1, exp1.pop_front());
                left1 = FL1 - 1;
            end
        end
    end

    function automatic logic rdy(input int d);
        return (d == 0) ? if0.cmd_ready_o : if1.cmd_ready_o;
    endfunction

    task automatic push_frame(input int d, input logic [7:0] w);
        bit fr[$];
        int b;
        b = (d == 0) ? 1 : 4;
        fr.push_back(1'b1);
        for (int i = 7; i >= 0; i--) fr.push_back(w[i]);
        fr.push_back(($countones(w) % 2) == 0);
        fr.push_back(1'b0);
        fr.push_back(1'b0);
        foreach (fr[k]) begin
            for (int r = 0; r < b; r++) begin
                if (d == 0) exp0.push_back(fr[k]);
                else exp1.push_back(fr[k]);
            end
        end
    endtask

    task automatic send(input int d, input logic [7:0] w, output int edge_n);
        int t;
        t = 0;
        @(negedge clk);
        if (d == 0) begin
            if0.cmd_data_i  = w;
            if0.cmd_valid_i = 1'b1;
        end else begin
            if1.cmd_data_i  = w;
            if1.cmd_valid_i = 1'b1;
        end
        while (!rdy(d) && t < 400) begin
            @(negedge clk);
            t++;
        end
        check("send_wait", rdy(d), 1);
        edge_n = cyc + 1;
        if (rdy(d)) push_frame(d, w);
        @(posedge clk);
    endtask

    task automatic drop();
        @(negedge clk);
        if0.cmd_valid_i = 1'b0;
        if1.cmd_valid_i = 1'b0;
    endtask

    task automatic drain(input int d);
        int t;
        t = 0;
        while (((d == 0) ? (exp0.size() != 0 || left0 != 0)
                         : (exp1.size() != 0 || left1 != 0)) && t < 3000) begin
            @(negedge clk);
            t++;
        end
        check("drain", t < 3000, 1);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        if0.cmd_valid_i = 1'b0;
        if1.cmd_valid_i = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        starts0.delete();
        starts1.delete();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        if0.cmd_valid_i = 1'b0;
        if0.cmd_data_i  = '0;
        if1.cmd_valid_i = 1'b0;
        if1.cmd_data_i  = '0;
        repeat (3) @(negedge clk);
        check("rst_cmd", cmd0, 0);
        check("rst_rdy", if0.cmd_ready_o, 0);
        check("rst_busy", busy0, 0);
        check("rst_cnt", cnt0, 0);
        check("rst_cnt1", cnt1, 0);
        rst = 1'b0;
        @(negedge clk);
        check("rdy_rise", if0.cmd_ready_o, 1);

        // single frame
        starts0.delete();
        send(0, 8'hA5, n);
        drop();
        @(negedge clk);
        check("t1_lead", cmd0, 0);
        check("t1_busy", busy0, 1);
        drain(0);
        check("t1_nstart", starts0.size(), 1);
        check("t1_start", (starts0.size() > 0) ? starts0[0] : -1, n + 2);
        check("t1_cnt", cnt0, 1);
        @(negedge clk);
        check("t1_idle", busy0, 0);

        // back-to-back with valid held high
        do_reset();
        send(0, 8'h00, n);
        send(0, 8'hFF, n);
        send(0, 8'h3C, n);
        @(negedge clk);
        check("t2_rdy_low", if0.cmd_ready_o, 0);
        if0.cmd_valid_i = 1'b0;
        drain(0);
        check("t2_nstart", starts0.size(), 3);
        if (starts0.size() == 3) begin
            check("t2_gap1", starts0[1] - starts0[0], FL0);
            check("t2_gap2", starts0[2] - starts0[1], FL0);
        end
        check("t2_cnt", cnt0, 3);

        // slow bit rate
        send(1, 8'h80, n);
        drop();
        drain(1);
        check("t3_cnt", cnt1, 1);
        check("t3_nstart", starts1.size(), 1);

        // reset mid-frame with a word held
        starts0.delete();
        send(0, 8'h5A, n);
        send(0, 8'h11, n);
        n = 0;
        while (starts0.size() == 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("t4_started", starts0.size(), 1);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        if0.cmd_valid_i = 1'b0;
        @(negedge clk);
        check("t4_cmd", cmd0, 0);
        check("t4_rdy", if0.cmd_ready_o, 0);
        check("t4_busy", busy0, 0);
        check("t4_cnt", cnt0, 0);
        rst = 1'b0;
        highs = 0;
        repeat (40) begin
            @(negedge clk);
            highs += int'(cmd0);
        end
        check("t4_quiet", highs, 0);
        check("t4_cnt_after", cnt0, 0);

        // counter wrap on the 4-bit instance
        for (int i = 0; i < 15; i++) send(1, 8'(i * 17 + 3), n);
        drop();
        drain(1);
        check("t5_15", cnt1, 15);
        send(1, 8'h69, n);
        drop();
        drain(1);
        check("t5_wrap", cnt1, 0);
        send(1, 8'h01, n);
        drop();
        drain(1);
        check("t5_one", cnt1, 1);

        // valid while not ready is ignored
        send(0, 8'h3C, n);
        @(negedge clk);
        if0.cmd_data_i  = 8'hC3;
        if0.cmd_valid_i = 1'b1;
        check("t6_rdy_low", if0.cmd_ready_o, 0);
        @(negedge clk);
        if0.cmd_valid_i = 1'b0;
        drain(0);
        highs = 0;
        repeat (30) begin
            @(negedge clk);
            highs += int'(cmd0);
        end
        check("t6_quiet", highs, 0);
        check("t6_cnt", cnt0, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
